// File: rtl/int_ctrl_if.sv
// Bus and CPU handshake signals of the interrupt controller; the CPU/bus side
// uses the master modport and int_ctrl uses the slave modport.
interface int_ctrl_if #(
    parameter int unsigned NUM_SRC = 6
);
    logic [3:2]         DEV_Addr;
    logic               WeDEV;
    logic [31:0]        DEV_WD;
    logic [31:0]        DEV_RD;
    logic [NUM_SRC-1:0] HWInt;
    logic               int_req;
    logic [2:0]         int_id;
    logic               int_ack;

    modport master (
        output DEV_Addr, WeDEV, DEV_WD, int_ack,
        input  DEV_RD, HWInt, int_req, int_id
    );

    modport slave (
        input  DEV_Addr, WeDEV, DEV_WD, int_ack,
        output DEV_RD, HWInt, int_req, int_id
    );
endinterface

// File: rtl/int_ctrl.sv
// Prioritised interrupt controller with MASK/MODE/PENDING/STATUS bus registers.
// Define INT_CTRL_EDGE_EN to add edge-triggered sources (MODE register, W1C).
module int_ctrl #(
    parameter int unsigned NUM_SRC = 6
) (
    input  logic               clk,
    input  logic               reset,
    int_ctrl_if.slave          bus,
    input  logic [NUM_SRC-1:0] irq_in
);
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        SERVICE = 2'b10
    } state_t;

    state_t             state, state_nx;
    logic [NUM_SRC-1:0] irq_q;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] active;
    logic [NUM_SRC-1:0] hw_int;
    logic [2:0]         sel;
    logic               found;
    logic               int_req, int_req_nx;
    logic [2:0]         int_id, int_id_nx;
    logic [2:0]         in_service, in_service_nx;
    logic               ack_take;
    logic               wr_mask, wr_status;
    logic [31:0]        rd;
    logic               unused_wd;

    assign wr_mask   = bus.WeDEV && (bus.DEV_Addr == 2'd0);
    assign wr_status = bus.WeDEV && (bus.DEV_Addr == 2'd3);
    assign unused_wd = ^bus.DEV_WD;

`ifdef INT_CTRL_EDGE_EN
    logic [NUM_SRC-1:0] mode;
    logic [NUM_SRC-1:0] pend_e, pend_e_nx;
    logic [NUM_SRC-1:0] w1c, ack_clr, rise;
    logic               wr_mode, wr_pend;

    assign wr_mode = bus.WeDEV && (bus.DEV_Addr == 2'd1);
    assign wr_pend = bus.WeDEV && (bus.DEV_Addr == 2'd2);
    assign rise    = irq_in & ~irq_q;
    assign w1c     = wr_pend ? bus.DEV_WD[NUM_SRC-1:0] : '0;
    assign ack_clr = ack_take ? (NUM_SRC'(1) << int_id) : '0;
    // Rising edge wins over clears; edge latches are dropped while a source is level.
    assign pend_e_nx = ((pend_e & ~(w1c | ack_clr)) | rise) & mode;
    assign pending   = (pend_e & mode) | (irq_q & ~mode);
`else
    assign pending = irq_q;
`endif

    assign active = pending & mask;

    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (active[i] && !found) begin
                sel   = 3'(i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx      = state;
        int_req_nx    = int_req;
        int_id_nx     = int_id;
        in_service_nx = in_service;
        ack_take      = 1'b0;
        case (state)
            IDLE: begin
                if (|active) begin
                    state_nx   = REQ;
                    int_req_nx = 1'b1;
                    int_id_nx  = sel;
                end
            end
            REQ: begin
                if (!(|active)) begin
                    state_nx   = IDLE;
                    int_req_nx = 1'b0;
                end else if (bus.int_ack) begin
                    state_nx      = SERVICE;
                    int_req_nx    = 1'b0;
                    in_service_nx = int_id;
                    ack_take      = 1'b1;
                end else begin
                    int_id_nx = sel;
                end
            end
            SERVICE: begin
                int_req_nx = 1'b0;
                if (wr_status) state_nx = IDLE;
            end
            default: begin
                state_nx   = IDLE;
                int_req_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            int_req    <= 1'b0;
            int_id     <= '0;
            in_service <= '0;
            irq_q      <= '0;
            mask       <= '0;
            hw_int     <= '0;
`ifdef INT_CTRL_EDGE_EN
            mode       <= '0;
            pend_e     <= '0;
`endif
        end else begin
            state      <= state_nx;
            int_req    <= int_req_nx;
            int_id     <= int_id_nx;
            in_service <= in_service_nx;
            irq_q      <= irq_in;
            hw_int     <= active;
            if (wr_mask) mask <= bus.DEV_WD[NUM_SRC-1:0];
`ifdef INT_CTRL_EDGE_EN
            if (wr_mode) mode <= bus.DEV_WD[NUM_SRC-1:0];
            pend_e <= pend_e_nx;
`endif
        end
    end

    always_comb begin
        rd = '0;
        case (bus.DEV_Addr)
            2'd0: rd[NUM_SRC-1:0] = mask;
`ifdef INT_CTRL_EDGE_EN
            2'd1: rd[NUM_SRC-1:0] = mode;
`else
            2'd1: rd = '0;
`endif
            2'd2: rd[NUM_SRC-1:0] = pending;
            2'd3: begin
                rd[9:8] = state;
                rd[6:4] = in_service;
                rd[2:0] = int_id;
            end
            default: rd = '0;
        endcase
    end

    assign bus.DEV_RD  = rd;
    assign bus.HWInt   = hw_int;
    assign bus.int_req = int_req;
    assign bus.int_id  = int_id;
endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_int_ctrl;
    localparam int unsigned NUM_SRC = 6;
    localparam int unsigned ALL     = (1 << NUM_SRC) - 1;
`ifdef INT_CTRL_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic [NUM_SRC-1:0] irq_in;
    logic               chk_en = 1'b0;
    int                 errors = 0;
    int                 checks = 0;

    int_ctrl_if #(.NUM_SRC(NUM_SRC)) bus ();

    int_ctrl #(.NUM_SRC(NUM_SRC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .irq_in(irq_in)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int unsigned m_irq_q, m_mask, m_mode, m_edge_pend;
    int unsigned m_state, m_req, m_id, m_isv, m_hw;

    function automatic int unsigned m_pending();
        if (EDGE) return ((m_edge_pend & m_mode) | (m_irq_q & ~m_mode)) & ALL;
        return m_irq_q & ALL;
    endfunction

    function automatic int unsigned lowest(input int unsigned a);
        for (int i = 0; i < NUM_SRC; i++)
            if (((a >> i) & 1) != 0) return i;
        return 0;
    endfunction

    function automatic int unsigned m_rd(input int unsigned addr);
        case (addr)
            0: return m_mask;
            1: return EDGE ? m_mode : 0;
            2: return m_pending();
            default: return (m_state << 8) | (m_isv << 4) | m_id;
        endcase
    endfunction

    always @(posedge clk) begin
        int unsigned act, rise, clr, wd, addr;
        if (!reset) begin
            m_irq_q = 0; m_mask = 0; m_mode = 0; m_edge_pend = 0;
            m_state = 0; m_req = 0; m_id = 0; m_isv = 0; m_hw = 0;
        end else begin
            act  = m_pending() & m_mask;
            wd   = bus.DEV_WD & ALL;
            addr = bus.DEV_Addr;
            rise = int'(irq_in) & ~m_irq_q & ALL;
            clr  = (bus.WeDEV && addr == 2) ? wd : 0;
            if (m_state == 0) begin
                if (act != 0) begin m_state = 1; m_req = 1; m_id = lowest(act); end
            end else if (m_state == 1) begin
                if (act == 0) begin
                    m_state = 0; m_req = 0;
                end else if (bus.int_ack) begin
                    m_isv = m_id; clr |= (1 << m_id);
                    m_state = 2; m_req = 0;
                end else begin
                    m_id = lowest(act);
                end
            end else if (bus.WeDEV && addr == 3) begin
                m_state = 0;
            end
            if (EDGE) m_edge_pend = ((m_edge_pend & ~clr) | rise) & m_mode;
            m_hw = act;
            if (bus.WeDEV && addr == 0) m_mask = wd;
            if (bus.WeDEV && addr == 1) m_mode = wd;
            m_irq_q = int'(irq_in);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model int_req", 32'(bus.int_req), m_req);
            chk("model int_id", 32'(bus.int_id), m_id);
            chk("model HWInt", 32'(bus.HWInt), m_hw);
            chk("model DEV_RD", bus.DEV_RD, m_rd(bus.DEV_Addr));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.DEV_Addr = a; bus.DEV_WD = d; bus.WeDEV = 1'b1;
        cyc(1);
        bus.WeDEV = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.DEV_Addr = a;
        #1;
        d = bus.DEV_RD;
    endtask

    task automatic do_reset();
        irq_in = '0; bus.int_ack = 1'b0; bus.WeDEV = 1'b0;
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
    endtask

    logic [31:0] v;

    initial begin
        reset = 1'b0; irq_in = '0;
        bus.DEV_Addr = '0; bus.WeDEV = 1'b0; bus.DEV_WD = '0; bus.int_ack = 1'b0;
        cyc(2);
        reset = 1'b1;
        chk_en = 1'b1;

        // reset state
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v); chk("reset rd", v, 32'h0);
        end
        chk("reset int_req", 32'(bus.int_req), 32'h0);
        chk("reset HWInt", 32'(bus.HWInt), 32'h0);

        // level source request / ack / EOI re-request
        do_reset();
        wr(2'd0, 32'h01);
        irq_in = 6'h01;
        cyc(1);
        rd(2'd2, v); chk("lvl pending", v, 32'h1);
        chk("lvl req early", 32'(bus.int_req), 32'h0);
        cyc(1);
        chk("lvl req", 32'(bus.int_req), 32'h1);
        chk("lvl id", 32'(bus.int_id), 32'h0);
        bus.int_ack = 1'b1; cyc(1); bus.int_ack = 1'b0;
        chk("lvl ack req", 32'(bus.int_req), 32'h0);
        rd(2'd3, v); chk("lvl status svc", v, 32'h200);
        wr(2'd3, 32'h0);
        rd(2'd3, v); chk("lvl status eoi", v, 32'h000);
        cyc(1);
        chk("lvl rereq", 32'(bus.int_req), 32'h1);
        rd(2'd3, v); chk("lvl status req", v, 32'h100);

        // priority
        do_reset();
        wr(2'd0, 32'h3F);
        irq_in = 6'h10;
        cyc(2);
        chk("prio req", 32'(bus.int_req), 32'h1);
        chk("prio id4", 32'(bus.int_id), 32'h4);
        irq_in = 6'h12;
        cyc(1);
        chk("prio id4 hold", 32'(bus.int_id), 32'h4);
        cyc(1);
        chk("prio id1", 32'(bus.int_id), 32'h1);
        bus.int_ack = 1'b1; cyc(1); bus.int_ack = 1'b0;
        rd(2'd3, v); chk("prio status", v, 32'h211);

        // masking
        do_reset();
        irq_in = 6'h3F;
        cyc(2);
        rd(2'd2, v); chk("mask pending", v, 32'h3F);
        chk("mask HWInt", 32'(bus.HWInt), 32'h0);
        chk("mask req", 32'(bus.int_req), 32'h0);
        wr(2'd0, 32'h20);
        cyc(1);
        chk("mask req5", 32'(bus.int_req), 32'h1);
        chk("mask id5", 32'(bus.int_id), 32'h5);
        wr(2'd0, 32'h0);
        chk("mask req hold", 32'(bus.int_req), 32'h1);
        cyc(1);
        chk("mask req drop", 32'(bus.int_req), 32'h0);
        rd(2'd3, v); chk("mask state idle", (v >> 8) & 32'h3, 32'h0);

        // reset during SERVICE
        do_reset();
        wr(2'd0, 32'h01);
        irq_in = 6'h01;
        cyc(2);
        bus.int_ack = 1'b1; cyc(1); bus.int_ack = 1'b0;
        rd(2'd3, v); chk("rst svc state", (v >> 8) & 32'h3, 32'h2);
        irq_in = '0;
        reset = 1'b0; cyc(1); reset = 1'b1;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v); chk("rst rd", v, 32'h0);
        end
        chk("rst req", 32'(bus.int_req), 32'h0);
        chk("rst HWInt", 32'(bus.HWInt), 32'h0);

`ifdef INT_CTRL_EDGE_EN
        // edge source with W1C colliding with a new edge, then ack clear
        do_reset();
        wr(2'd1, 32'h04);
        irq_in = 6'h04;
        cyc(1);
        irq_in = '0;
        rd(2'd2, v); chk("edge pending", v, 32'h04);
        cyc(1);
        irq_in = 6'h04;
        bus.DEV_Addr = 2'd2; bus.DEV_WD = 32'h04; bus.WeDEV = 1'b1;
        cyc(1);
        bus.WeDEV = 1'b0; irq_in = '0;
        rd(2'd2, v); chk("edge set wins", v, 32'h04);
        wr(2'd0, 32'h04);
        cyc(1);
        chk("edge req", 32'(bus.int_req), 32'h1);
        chk("edge id2", 32'(bus.int_id), 32'h2);
        bus.int_ack = 1'b1; cyc(1); bus.int_ack = 1'b0;
        rd(2'd2, v); chk("edge ack clr", v, 32'h0);
`else
        // no edge support: MODE stuck at 0, pending follows irq_q
        do_reset();
        wr(2'd1, 32'hFF);
        rd(2'd1, v); chk("mode ro", v, 32'h0);
        irq_in = 6'h08;
        cyc(1);
        irq_in = '0;
        rd(2'd2, v); chk("lvl pulse on", v, 32'h08);
        cyc(1);
        rd(2'd2, v); chk("lvl pulse off", v, 32'h0);
`endif

        // randomized traffic checked by the model
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 3) == 0) irq_in = NUM_SRC'($urandom);
            bus.WeDEV    = ($urandom_range(0, 5) == 0);
            bus.DEV_Addr = 2'($urandom);
            bus.DEV_WD   = $urandom;
            bus.int_ack  = ($urandom_range(0, 2) == 0);
            cyc(1);
        end
        reset = 1'b1; bus.WeDEV = 1'b0; bus.int_ack = 1'b0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
